// File: rtl/id_stage_buffer_if.sv
// Fetch-to-decode handshake bundle for id_stage_buffer: upstream valid/ready
// with instruction+PC, downstream valid/ready with split instruction fields.
interface id_stage_buffer_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [PC_W-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  out_pc;
  logic [5:0]       out_opcode;
  logic [4:0]       out_rs;
  logic [4:0]       out_rt;
  logic [4:0]       out_rd;
  logic [4:0]       out_shamt;
  logic [5:0]       out_funct;
  logic [15:0]      out_imm16;
  logic [25:0]      out_target;
  logic [1:0]       out_type;
  logic [CNT_W-1:0] out_count;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt, out_rd,
           out_shamt, out_funct, out_imm16, out_target, out_type, out_count
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt, out_rd,
           out_shamt, out_funct, out_imm16, out_target, out_type, out_count
  );
endinterface

// File: rtl/id_stage_buffer.sv
// Decode-stage 2-entry skid buffer: absorbs one stall cycle from decode, supports
// branch flush, and presents the head instruction already split into MIPS fields.
module id_stage_buffer #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               reset,
  input logic               flush,
  id_stage_buffer_if.slave  bus
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state, state_n;
  logic [31:0]      head_instr, skid_instr, head_vis;
  logic [PC_W-1:0]  head_pc, skid_pc;
  logic [CNT_W-1:0] count;
  logic             push, pop, head_load, head_shift, skid_load;

  function automatic logic [1:0] instr_type(input logic [5:0] op);
    if (op == 6'd0)
      instr_type = 2'b00;
    else if (op == 6'd2 || op == 6'd3)
      instr_type = 2'b10;
    else
      instr_type = 2'b01;
  endfunction

  // ready depends on state alone so fetch never sees a combinational path from decode
  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_comb begin
    state_n    = state;
    head_load  = 1'b0;
    head_shift = 1'b0;
    skid_load  = 1'b0;
    unique case (state)
      EMPTY: if (push) begin
        head_load = 1'b1;
        state_n   = ONE;
      end
      ONE: begin
        if (push && pop) begin
          head_load = 1'b1;
        end else if (push) begin
          skid_load = 1'b1;
          state_n   = FULL;
        end else if (pop) begin
          state_n = EMPTY;
        end
      end
      FULL: if (pop) begin
        head_shift = 1'b1;
        state_n    = ONE;
      end
      default: state_n = EMPTY;
    endcase
    if (flush) begin
      state_n    = EMPTY;
      head_load  = 1'b0;
      head_shift = 1'b0;
      skid_load  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= EMPTY;
    else
      state <= state_n;
  end

  // storage stage: head/skid registers
  always_ff @(posedge clk) begin
    if (reset) begin
      head_instr <= '0;
      head_pc    <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      if (head_load) begin
        head_instr <= bus.in_instr;
        head_pc    <= bus.in_pc;
      end else if (head_shift) begin
        head_instr <= skid_instr;
        head_pc    <= skid_pc;
      end
      if (skid_load) begin
        skid_instr <= bus.in_instr;
        skid_pc    <= bus.in_pc;
      end else if (head_shift) begin
        skid_instr <= '0;
        skid_pc    <= '0;
      end
    end
  end

  // a pop coinciding with flush is discarded, so it is not counted
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (pop && !flush)
      count <= count + 1'b1;
  end

  // output stage: field slices of the masked head entry
  assign head_vis       = bus.out_valid ? head_instr : 32'd0;
  assign bus.out_pc     = bus.out_valid ? head_pc : '0;
  assign bus.out_opcode = head_vis[31:26];
  assign bus.out_rs     = head_vis[25:21];
  assign bus.out_rt     = head_vis[20:16];
  assign bus.out_rd     = head_vis[15:11];
  assign bus.out_shamt  = head_vis[10:6];
  assign bus.out_funct  = head_vis[5:0];
  assign bus.out_imm16  = head_vis[15:0];
  assign bus.out_target = head_vis[25:0];
  assign bus.out_type   = instr_type(head_vis[31:26]);
  assign bus.out_count  = count;
endmodule

// File: tb/tb_id_stage_buffer.sv
// Directed bench for id_stage_buffer: a queue scoreboard records accepted
// instructions and checks every head output cycle by cycle.
module tb_id_stage_buffer;
  localparam int PC_W  = 32;
  localparam int CNT_W = 8;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic reset, flush;
  int   tests = 0;
  int   fails = 0;
  ent_t sb[$];
  logic [CNT_W-1:0] cnt_m;
  int   delivered = 0;
  bit   did_push;

  id_stage_buffer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  id_stage_buffer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the scoreboard head, then advance the model.
  task automatic cyc();
    logic [31:0] ei, ep;
    logic [1:0]  et;
    bit er, ev, pu, po;
    @(negedge clk);
    er = sb.size() < 2;
    ev = sb.size() > 0;
    ei = ev ? sb[0].instr : 32'd0;
    ep = ev ? sb[0].pc : 32'd0;
    if (!ev || ei[31:26] == 6'd0) et = 2'b00;
    else if (ei[31:26] == 6'd2 || ei[31:26] == 6'd3) et = 2'b10;
    else et = 2'b01;
    chk("in_ready", bus.in_ready, er);
    chk("out_valid", bus.out_valid, ev);
    chk("out_count", bus.out_count, cnt_m);
    chk("out_pc", bus.out_pc, ep);
    chk("out_opcode", bus.out_opcode, ei[31:26]);
    chk("out_rs", bus.out_rs, ei[25:21]);
    chk("out_rt", bus.out_rt, ei[20:16]);
    chk("out_rd", bus.out_rd, ei[15:11]);
    chk("out_shamt", bus.out_shamt, ei[10:6]);
    chk("out_funct", bus.out_funct, ei[5:0]);
    chk("out_imm16", bus.out_imm16, ei[15:0]);
    chk("out_target", bus.out_target, ei[25:0]);
    chk("out_type", bus.out_type, et);
    pu = bus.in_valid && er;
    po = ev && bus.out_ready;
    if (reset) begin
      sb.delete();
      cnt_m = '0;
    end else if (flush) begin
      sb.delete();
    end else begin
      if (po) begin
        void'(sb.pop_front());
        cnt_m++;
        delivered++;
      end
      if (pu) sb.push_back('{instr: bus.in_instr, pc: bus.in_pc});
    end
    did_push = pu && !reset && !flush;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask

  logic [31:0] tbl [8] = '{32'h8C220004, 32'h00851022, 32'h08000010, 32'h3C01ABCD,
                           32'h00031080, 32'h0C0000FF, 32'hAC450008, 32'h1022FFFE};

  initial begin
    int k, d0, n;
    logic [CNT_W-1:0] c0;
    reset = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    cnt_m = '0;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_count", bus.out_count, 0);

    // 1: single instruction, one-cycle latency, field split
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h200101DD, 32'h0);
    cyc();
    drive(1'b0, 32'd0, 32'd0);
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_opcode", bus.out_opcode, 32'h08);
    chk("t1_rs", bus.out_rs, 0);
    chk("t1_rt", bus.out_rt, 1);
    chk("t1_imm16", bus.out_imm16, 32'h01DD);
    chk("t1_type", bus.out_type, 2'b01);
    cyc();
    chk("t1_count", bus.out_count, 1);

    // 2: fill to FULL under stall, third push refused, drain in order
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h2001AFDE, 32'h4);
    cyc();
    drive(1'b1, 32'h00221820, 32'h8);
    cyc();
    chk("t2_full_ready", bus.in_ready, 0);
    drive(1'b1, 32'hFFFFFFFF, 32'hC);
    cyc();
    drive(1'b0, 32'd0, 32'd0);
    bus.out_ready = 1'b1;
    chk("t2_head0_imm", bus.out_imm16, 32'hAFDE);
    chk("t2_head0_pc", bus.out_pc, 32'h4);
    cyc();
    chk("t2_head1_type", bus.out_type, 2'b00);
    chk("t2_head1_rd", bus.out_rd, 3);
    chk("t2_head1_funct", bus.out_funct, 32'h20);
    cyc();
    chk("t2_count", bus.out_count, 3);
    cyc();

    // 3: stream 8 with out_ready toggling
    d0 = delivered;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      if (k < 8) drive(1'b1, tbl[k], 32'h100 + 32'(4 * k));
      else drive(1'b0, 32'd0, 32'd0);
      bus.out_ready = (c % 2 == 0);
      cyc();
      if (did_push) k++;
    end
    chk("t3_accepted", k, 8);
    chk("t3_delivered", delivered - d0, 8);

    // 4: flush while FULL with concurrent push and pop
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h24420001, 32'h200);
    cyc();
    drive(1'b1, 32'h24630002, 32'h204);
    cyc();
    c0 = bus.out_count;
    flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h24840003, 32'h208);
    cyc();
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    chk("t4_valid", bus.out_valid, 0);
    chk("t4_ready", bus.in_ready, 1);
    chk("t4_count", bus.out_count, c0);
    repeat (2) cyc();

    // 5: J-type decode, then pop until the counter wraps
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h0C000040, 32'h300);
    cyc();
    chk("t5_type", bus.out_type, 2'b10);
    chk("t5_target", bus.out_target, 32'h40);
    n = (1 << CNT_W) - int'(cnt_m);
    bus.out_ready = 1'b1;
    for (int i = 0; i < n - 1; i++) begin
      drive(1'b1, 32'h20000000 | 32'(i), 32'h400 + 32'(4 * i));
      cyc();
    end
    chk("t5_count_max", bus.out_count, {CNT_W{1'b1}});
    drive(1'b0, 32'd0, 32'd0);
    cyc();
    chk("t5_count_wrap", bus.out_count, 0);

    // 6: reset beats flush while FULL
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h11111111, 32'h500);
    cyc();
    drive(1'b1, 32'h22222222, 32'h504);
    cyc();
    reset = 1'b1;
    flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h33333333, 32'h508);
    cyc();
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    chk("t6_valid", bus.out_valid, 0);
    chk("t6_ready", bus.in_ready, 1);
    chk("t6_count", bus.out_count, 0);
    chk("t6_pc", bus.out_pc, 0);
    chk("t6_imm16", bus.out_imm16, 0);
    chk("t6_type", bus.out_type, 0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
